// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst master: single/linear/wrap4/8/16 read and write commands
// from a local engine become registered-feedback bus cycles. Write beats are
// pulled through a one-entry data register; read beats are pushed out with
// no backpressure.
// Optional feature: define WB_B3_MASTER_TIMEOUT_EN to build the strobe
// watchdog (abort after TIMEOUT unanswered strobe cycles).
module wb_b3_burst_master #(
    parameter int aw      = 32,
    parameter int dw      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [aw-1:0] cmd_adr_i,
    input  logic [3:0]    cmd_len_m1_i,
    input  logic [1:0]    cmd_bte_i,
    input  logic [dw-1:0] wdata_i,
    input  logic          wdata_valid_i,
    output logic          wdata_ready_o,
    output logic [dw-1:0] rdata_o,
    output logic          rdata_valid_o,
    output logic          done_o,
    output logic          done_err_o,
    output logic          done_timeout_o,
    output logic [4:0]    beats_done_o,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);
    typedef enum logic {S_IDLE, S_XFER} state_e;
    localparam int WW = aw - 2;

    state_e        state_q;
    logic          we_q;
    logic [1:0]    bte_q;
    logic [3:0]    cnt_q;
    logic [WW-1:0] wadr_q;
    logic [4:0]    acks_q;
    logic [4:0]    wrem_q;
    logic          wfull_q;
    logic [dw-1:0] wdat_q;
    logic          cyc_q;
    logic [2:0]    cti_q;
    logic [dw-1:0] rdata_q;
    logic          rvld_q;
    logic          done_q;
    logic          done_err_q;
    logic          done_to_q;
    logic [4:0]    beats_q;

    logic          accept;
    logic          stb;
    logic          ack;
    logic          ack_ok;
    logic          abort_bus;
    logic          timeout_hit;
    logic          wload;
    logic          last;
    logic [WW-1:0] wrap_mask;
    logic [WW-1:0] wadr_inc;
    logic [WW-1:0] wadr_nxt;

    assign cmd_ready_o = (state_q == S_IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;
    // writes only strobe once the beat's data is sitting in the register
    assign stb         = cyc_q && (!we_q || wfull_q);
    assign ack         = stb && wb_ack_i;
    assign abort_bus   = stb && (wb_err_i || wb_rty_i);
    assign ack_ok      = ack && !abort_bus;
    assign last        = (cnt_q == 4'd0);
    // the first write beat may load during the accept cycle so the strobe can
    // rise together with cyc; later beats refill as the current one is acked,
    // and no more beats are pulled than the command needs
    assign wdata_ready_o = (accept && cmd_we_i) ||
                           ((state_q == S_XFER) && we_q && (wrem_q != 5'd0) &&
                            (!wfull_q || ack_ok));
    assign wload = wdata_valid_i && wdata_ready_o;

`ifdef WB_B3_MASTER_TIMEOUT_EN
    localparam int WDW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q;

    // abort in the cycle that would be the TIMEOUT-th unanswered strobe cycle
    assign timeout_hit = stb && !wb_ack_i && !wb_err_i && !wb_rty_i &&
                         (wd_q == WDW'(TIMEOUT - 1));

    // watchdog: counts strobe cycles without any slave response
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wd_q <= '0;
        end else if (!cyc_q || ack) begin
            wd_q <= '0;
        end else if (stb && !wb_err_i && !wb_rty_i) begin
            wd_q <= wd_q + WDW'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    // next word address: wrap modes only advance the low bits inside the block
    always_comb begin
        case (bte_q)
            2'b01:   wrap_mask = WW'(3);
            2'b10:   wrap_mask = WW'(7);
            2'b11:   wrap_mask = WW'(15);
            default: wrap_mask = '1;
        endcase
        wadr_inc = wadr_q + WW'(1);
        wadr_nxt = (wadr_q & ~wrap_mask) | (wadr_inc & wrap_mask);
    end

    // command FSM: bus control, beat accounting, read return and completion
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            bte_q      <= 2'b00;
            cnt_q      <= 4'd0;
            wadr_q     <= '0;
            acks_q     <= 5'd0;
            cyc_q      <= 1'b0;
            cti_q      <= 3'b000;
            rdata_q    <= '0;
            rvld_q     <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            done_to_q  <= 1'b0;
            beats_q    <= 5'd0;
        end else begin
            rvld_q     <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            done_to_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= S_XFER;
                        we_q    <= cmd_we_i;
                        bte_q   <= cmd_bte_i;
                        cnt_q   <= cmd_len_m1_i;
                        wadr_q  <= cmd_adr_i[aw-1:2];
                        acks_q  <= 5'd0;
                        cyc_q   <= 1'b1;
                        cti_q   <= (cmd_len_m1_i == 4'd0) ? 3'b000 : 3'b010;
                    end
                end
                default: begin
                    // err/rty/timeout wins over a simultaneous ack
                    if (abort_bus || timeout_hit) begin
                        state_q    <= S_IDLE;
                        cyc_q      <= 1'b0;
                        done_q     <= 1'b1;
                        done_err_q <= 1'b1;
                        done_to_q  <= timeout_hit;
                        beats_q    <= acks_q;
                    end else if (ack) begin
                        if (!we_q) begin
                            rdata_q <= wb_dat_i;
                            rvld_q  <= 1'b1;
                        end
                        if (last) begin
                            state_q <= S_IDLE;
                            cyc_q   <= 1'b0;
                            done_q  <= 1'b1;
                            beats_q <= acks_q + 5'd1;
                        end else begin
                            cnt_q  <= cnt_q - 4'd1;
                            wadr_q <= wadr_nxt;
                            acks_q <= acks_q + 5'd1;
                            cti_q  <= (cnt_q == 4'd1) ? 3'b111 : 3'b010;
                        end
                    end
                end
            endcase
        end
    end

    // write data register: one beat held until acked, refilled on the same edge
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wfull_q <= 1'b0;
            wdat_q  <= '0;
            wrem_q  <= 5'd0;
        end else begin
            if (accept) begin
                wrem_q <= cmd_we_i ? ({1'b0, cmd_len_m1_i} + 5'd1 - {4'd0, wload}) : 5'd0;
            end else if (wload) begin
                wrem_q <= wrem_q - 5'd1;
            end
            if (wload) begin
                wdat_q  <= wdata_i;
                wfull_q <= 1'b1;
            end else if (ack || abort_bus || timeout_hit) begin
                wfull_q <= 1'b0;
            end
        end
    end

    assign wb_adr_o       = {wadr_q, 2'b00};
    assign wb_dat_o       = wdat_q;
    assign wb_sel_o       = 4'hf;
    assign wb_we_o        = we_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = stb;
    assign wb_cti_o       = cti_q;
    assign wb_bte_o       = bte_q;
    assign rdata_o        = rdata_q;
    assign rdata_valid_o  = rvld_q;
    assign done_o         = done_q;
    assign done_err_o     = done_err_q;
    assign done_timeout_o = done_to_q;
    assign beats_done_o   = beats_q;
endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Randomized scoreboard bench for wb_b3_burst_master: a driver issues commands,
// feeds write beats and plays a Wishbone slave; a reference model queues the
// expected bus beats, read beats and completions; a monitor pops and compares.
`timescale 1ns/1ps
module tb_wb_b3_burst_master;
    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [3:0]  cmd_len_m1_i;
    logic [1:0]  cmd_bte_i;
    logic [31:0] wdata_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, done_o, done_err_o, done_timeout_o;
    logic [4:0]  beats_done_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;

    always #5 clk = ~clk;

    wb_b3_burst_master #(.aw(32), .dw(32), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_len_m1_i(cmd_len_m1_i), .cmd_bte_i(cmd_bte_i),
        .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .done_o(done_o), .done_err_o(done_err_o), .done_timeout_o(done_timeout_o),
        .beats_done_o(beats_done_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    typedef struct {
        logic [31:0] adr; logic [2:0] cti; logic [1:0] bte; logic we; logic [31:0] dat;
    } beat_t;
    typedef struct { logic err; logic to; logic [4:0] beats; } done_t;
    typedef struct {
        bit we; logic [31:0] adr; logic [3:0] len; logic [1:0] bte;
        int err_at; bit mute; bit wall; int stall_n; bit seq;
    } cmd_t;

    beat_t       exp_beat_q[$];
    logic [31:0] exp_rd_q[$];
    done_t       exp_done_q[$];
    cmd_t        cmds[$];
    logic [31:0] wq[$];

    int n_chk = 0, n_fail = 0;
    int cyc_cnt = 0;
    bit busy = 0, hs_w = 0, hs_a = 0, slv_mute = 0, w_all = 0, mute_on = 0;
    int gap = 0, slv_beat = 0, slv_wait = 0, slv_err_at = -1, w_taken = 0, stall_n = 0;
    int mute_stb = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // read data the slave returns for a given word address
    function automatic logic [31:0] rd_pat(input logic [29:0] w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // reference model: expected bus beats, read beats and completion of a command
    task automatic model_cmd(input bit we, input logic [31:0] adr, input logic [3:0] len,
                             input logic [1:0] bte, input int err_at, input logic [31:0] wd[$]);
        logic [29:0] start, w, mask;
        int nb, wl, ln;
        beat_t b;
        done_t d;
        ln    = int'(len);
        start = adr[31:2];
        wl    = 2 << int'(bte);
        mask  = (bte == 2'b00) ? '1 : 30'(wl - 1);
        nb    = (err_at >= 0) ? err_at + 1 : ln + 1;
        for (int i = 0; i < nb; i++) begin
            w     = (start & ~mask) | ((start + 30'(i)) & mask);
            b.adr = {w, 2'b00};
            b.cti = (ln == 0) ? 3'b000 : ((i == ln) ? 3'b111 : 3'b010);
            b.bte = bte;
            b.we  = we;
            b.dat = we ? wd[i] : 32'h0;
            exp_beat_q.push_back(b);
            if (!we && i != err_at) exp_rd_q.push_back(rd_pat(w));
        end
        d.err   = (err_at >= 0);
        d.to    = 1'b0;
        d.beats = (err_at >= 0) ? 5'(err_at) : 5'(ln + 1);
        exp_done_q.push_back(d);
    endtask

    // one clock of stimulus: command issue, write stream and slave responses
    task automatic run_cycle();
        cmd_t        c;
        done_t       d;
        logic [31:0] tmp;
        @(negedge clk);
        cyc_cnt++;
        if (hs_w) begin tmp = wq.pop_front(); w_taken++; end
        if (hs_a) begin
            slv_beat++;
            slv_wait = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        end
        if (!wb_cyc_o) slv_beat = 0;
        if (done_o) begin
            busy = 0;
            wq.delete();
            if (mute_on) begin
                check("timeout_stb_cycles", 32'(mute_stb), 32'(TO));
                mute_on  = 0;
                slv_mute = 0;
            end
        end
        if (slv_mute && wb_stb_o) mute_stb++;
        cmd_valid_i = 1'b0;
        if (!busy && gap > 0) begin
            gap--;
        end else if (!busy && cmds.size() > 0) begin
            c = cmds.pop_front();
            check("cmd_ready_at_issue", 32'(cmd_ready_o), 32'd1);
            cmd_valid_i  = 1'b1;
            cmd_we_i     = c.we;
            cmd_adr_i    = c.adr;
            cmd_len_m1_i = c.len;
            cmd_bte_i    = c.bte;
            wq.delete();
            w_taken = 0;
            if (c.we)
                for (int i = 0; i <= int'(c.len); i++)
                    wq.push_back(c.seq ? 32'(i + 1) : $urandom);
            slv_err_at = c.err_at;
            slv_mute   = c.mute;
            slv_wait   = int'($urandom_range(0, 1));
            w_all      = c.wall;
            stall_n    = c.stall_n;
            if (c.mute) begin
                d.err = 1'b1; d.to = 1'b1; d.beats = 5'd0;
                exp_done_q.push_back(d);
                mute_stb = 0;
                mute_on  = 1;
            end else begin
                model_cmd(c.we, c.adr, c.len, c.bte, c.err_at, wq);
            end
            busy = 1;
            gap  = int'($urandom_range(0, 2));
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = $urandom;
        if (wb_cyc_o && wb_stb_o && !slv_mute) begin
            if (slv_wait > 0) begin
                slv_wait--;
            end else if (slv_beat == slv_err_at) begin
                if ($urandom_range(0, 1) == 1) wb_err_i = 1'b1; else wb_rty_i = 1'b1;
                wb_ack_i = 1'($urandom_range(0, 1));
            end else begin
                wb_ack_i = 1'b1;
                wb_dat_i = rd_pat(wb_adr_o[31:2]);
            end
        end
        wdata_valid_i = 1'b0;
        wdata_i       = $urandom;
        if (wq.size() > 0) begin
            if (stall_n > 0 && w_taken == 1) begin
                stall_n--;
            end else if (w_all || $urandom_range(0, 3) != 0) begin
                wdata_valid_i = 1'b1;
                wdata_i       = wq[0];
            end
        end
        #1;
        hs_w = wdata_valid_i && wdata_ready_o;
        hs_a = wb_ack_i && !wb_err_i && !wb_rty_i && wb_stb_o && wb_cyc_o;
    endtask

    // monitor: compares every bus beat, read beat and completion against the model
    always begin : mon
        beat_t       b;
        done_t       d;
        logic [31:0] r;
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i)) begin
                if (exp_beat_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL beat_unexpected: adr %h, expected no beat", wb_adr_o);
                end else begin
                    b = exp_beat_q.pop_front();
                    check("beat_adr", wb_adr_o, b.adr);
                    check("beat_cti", 32'(wb_cti_o), 32'(b.cti));
                    check("beat_bte", 32'(wb_bte_o), 32'(b.bte));
                    check("beat_we", 32'(wb_we_o), 32'(b.we));
                    check("beat_sel", 32'(wb_sel_o), 32'hf);
                    if (b.we) check("beat_wdat", wb_dat_o, b.dat);
                end
            end
            if (rdata_valid_o) begin
                if (exp_rd_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rdata_unexpected: got %h, expected no beat", rdata_o);
                end else begin
                    r = exp_rd_q.pop_front();
                    check("rdata", rdata_o, r);
                end
            end
            if (done_o) begin
                if (exp_done_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL done_unexpected: got done, expected none");
                end else begin
                    d = exp_done_q.pop_front();
                    check("done_err", 32'(done_err_o), 32'(d.err));
                    check("done_timeout", 32'(done_timeout_o), 32'(d.to));
                    check("beats_done", 32'(beats_done_o), 32'(d.beats));
                end
            end
        end
    end

    function automatic cmd_t mk(input bit we, input logic [31:0] adr, input logic [3:0] len,
                                input logic [1:0] bte, input int err_at);
        cmd_t c;
        c.we = we; c.adr = adr; c.len = len; c.bte = bte; c.err_at = err_at;
        c.mute = 0; c.wall = 0; c.stall_n = 0; c.seq = 0;
        return c;
    endfunction

    initial begin
        cmd_t c;
        int   lim;
        cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = 0; cmd_len_m1_i = 0; cmd_bte_i = 0;
        wdata_i = 0; wdata_valid_i = 0; wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
        #3;
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_cti", 32'(wb_cti_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_rvalid", 32'(rdata_valid_o), 32'd0);
        check("rst_wready", 32'(wdata_ready_o), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        cmds.push_back(mk(0, 32'h0000_0100, 4'd0, 2'b00, -1));
        c = mk(1, 32'h0000_0FF8, 4'd3, 2'b00, -1); c.wall = 1; c.seq = 1; cmds.push_back(c);
        cmds.push_back(mk(0, 32'h0000_0018, 4'd7, 2'b10, -1));
        c = mk(1, 32'h0000_0040, 4'd3, 2'b00, -1); c.wall = 1; c.stall_n = 3; cmds.push_back(c);
        cmds.push_back(mk(0, 32'h0000_0200, 4'd15, 2'b00, 2));
        cmds.push_back(mk(1, 32'hFFFF_FFF8, 4'd3, 2'b00, -1));
        for (int i = 0; i < 60; i++) begin
            c = mk(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), -1);
            if ($urandom_range(0, 4) == 0) c.err_at = int'($urandom_range(0, int'(c.len)));
            cmds.push_back(c);
        end
`ifdef WB_B3_MASTER_TIMEOUT_EN
        c = mk(0, 32'h0000_0300, 4'd3, 2'b00, -1); c.mute = 1; cmds.push_back(c);
        cmds.push_back(mk(0, 32'h0000_0400, 4'd1, 2'b00, -1));
`endif

        while ((cmds.size() > 0 || busy) && cyc_cnt < 40000) run_cycle();
        if (cmds.size() > 0 || busy) begin
            n_chk++; n_fail++;
            $display("FAIL cmd_drain: %0d commands left after %0d cycles, expected 0", cmds.size(), cyc_cnt);
        end
        repeat (3) run_cycle();
        check("left_beats", 32'(exp_beat_q.size()), 32'd0);
        check("left_rdata", 32'(exp_rd_q.size()), 32'd0);
        check("left_done", 32'(exp_done_q.size()), 32'd0);

        // asynchronous reset in the middle of a 16-beat read
        cmds.push_back(mk(0, 32'h0000_0800, 4'd15, 2'b00, -1));
        lim = 0;
        while (!(busy && wb_cyc_o) && lim < 20) begin run_cycle(); lim++; end
        repeat (3) run_cycle();
        check("pre_reset_cyc", 32'(wb_cyc_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("async_rst_stb", 32'(wb_stb_o), 32'd0);
        check("async_rst_ready", 32'(cmd_ready_o), 32'd1);
        check("async_rst_done", 32'(done_o), 32'd0);
        exp_beat_q.delete(); exp_rd_q.delete(); exp_done_q.delete();
        busy = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
